// File: rtl/spram_burst_ctrl_if.sv
// rtl/spram_burst_ctrl_if.sv - host command, write-beat and read-beat bundle for spram_burst_ctrl
interface spram_burst_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 14,
    parameter int LANES  = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W-1:0] cmd_len;
    logic [LANES-1:0]  cmd_mask;
    logic [DATA_W-1:0] cmd_seed;
    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] err_addr;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_mask, cmd_seed, wr_data, wr_valid,
        input  cmd_ready, wr_ready, rd_data, rd_valid, done, err, err_addr
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_mask, cmd_seed, wr_data, wr_valid,
        output cmd_ready, wr_ready, rd_data, rd_valid, done, err, err_addr
    );
endinterface

// File: rtl/spram_burst_ctrl.sv
// rtl/spram_burst_ctrl.sv - burst WRITE/READ/FILL/VERIFY sequencer driving one single-port RAM
module spram_burst_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 14,
    parameter int LANES  = 4
) (
    input  logic              clk,
    input  logic              reset,
    spram_burst_ctrl_if.slave bus,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LANES-1:0]  mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_FILL, S_READ, S_DRAIN, S_DONE} state_t;

    localparam logic [1:0] OP_WRITE  = 2'b00;
    localparam logic [1:0] OP_FILL   = 2'b10;
    localparam logic [1:0] OP_VERIFY = 2'b11;

    state_t            state, state_n;
    logic [ADDR_W-1:0] cur, len, beat;
    logic [LANES-1:0]  mask;
    logic [DATA_W-1:0] seed;
    logic              verify;
    logic              rd_pend;
    logic [ADDR_W-1:0] rd_beat, rd_addr;
    logic              err_q;
    logic [ADDR_W-1:0] err_addr_q;

    logic              cmd_ready, wr_ready, adv, issue, last, accept, mismatch;
    logic [LANES-1:0]  we_raw;
    logic [DATA_W-1:0] expect_word;

    assign last        = (beat == len);
    assign accept      = (state == S_IDLE) && bus.cmd_valid;
    assign expect_word = seed + DATA_W'(rd_beat);
    assign mismatch    = rd_pend && verify && (mem_rdata != expect_word);

    always_comb begin
        state_n   = state;
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        adv       = 1'b0;
        issue     = 1'b0;
        we_raw    = '0;
        mem_addr  = cur;
        mem_wdata = bus.wr_data;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    case (bus.cmd_op)
                        OP_WRITE: state_n = S_WRITE;
                        OP_FILL:  state_n = S_FILL;
                        default:  state_n = S_READ;
                    endcase
                end
            end
            S_WRITE: begin
                wr_ready = 1'b1;
                if (bus.wr_valid) begin
                    we_raw = mask;
                    adv    = 1'b1;
                    if (last) state_n = S_DONE;
                end
            end
            S_FILL: begin
                we_raw    = '1;
                mem_wdata = seed + DATA_W'(beat);
                adv       = 1'b1;
                if (last) state_n = S_DONE;
            end
            S_READ: begin
                issue = 1'b1;
                adv   = 1'b1;
                if (last) state_n = S_DRAIN;
            end
            S_DRAIN: state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Write strobes are cut combinationally so a reset mid-burst never lands one more beat.
    assign mem_we = reset ? we_raw : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            cur        <= '0;
            len        <= '0;
            beat       <= '0;
            mask       <= '0;
            seed       <= '0;
            verify     <= 1'b0;
            rd_pend    <= 1'b0;
            rd_beat    <= '0;
            rd_addr    <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state   <= state_n;
            rd_pend <= issue;
            rd_beat <= beat;
            rd_addr <= cur;
            if (mismatch && !err_q) begin
                err_q      <= 1'b1;
                err_addr_q <= rd_addr;
            end
            if (accept) begin
                cur    <= bus.cmd_addr;
                len    <= bus.cmd_len;
                mask   <= bus.cmd_mask;
                seed   <= bus.cmd_seed;
                beat   <= '0;
                verify <= (bus.cmd_op == OP_VERIFY);
                if (bus.cmd_op == OP_VERIFY) begin
                    err_q      <= 1'b0;
                    err_addr_q <= '0;
                end
            end else if (adv) begin
                cur  <= cur + 1'b1;
                beat <= beat + 1'b1;
            end
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.wr_ready  = wr_ready;
    assign bus.rd_data   = mem_rdata;
    assign bus.rd_valid  = rd_pend;
    assign bus.done      = (state == S_DONE);
    assign bus.err       = err_q;
    assign bus.err_addr  = err_addr_q;
endmodule

// File: tb/tb_spram_burst_ctrl.sv
// tb/tb_spram_burst_ctrl.sv - scoreboard bench for spram_burst_ctrl with a behavioural SPRAM
module tb_spram_burst_ctrl;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 14;
    localparam int LANES  = 4;
    localparam int LW     = DATA_W / LANES;

    localparam logic [1:0] OP_WRITE  = 2'b00;
    localparam logic [1:0] OP_READ   = 2'b01;
    localparam logic [1:0] OP_FILL   = 2'b10;
    localparam logic [1:0] OP_VERIFY = 2'b11;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    spram_burst_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LANES(LANES)) bus ();

    logic [ADDR_W-1:0] mem_addr;
    logic [LANES-1:0]  mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    spram_burst_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LANES(LANES)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        for (int l = 0; l < LANES; l++)
            if (mem_we[l]) ram[mem_addr][l*LW +: LW] <= mem_wdata[l*LW +: LW];
        mem_rdata <= ram[mem_addr];
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct { logic [DATA_W-1:0] data; int cyc; } rd_exp_t;
    typedef struct { logic [ADDR_W-1:0] addr; logic [LANES-1:0] we; logic [DATA_W-1:0] data; } wr_obs_t;
    rd_exp_t rd_q[$];
    wr_obs_t wr_log[$];
    int done_count = 0;
    int done_cyc   = -1;

    always @(negedge clk) begin
        if (bus.rd_valid) begin
            if (rd_q.size() == 0) begin
                check_eq("rd_unexpected", 32'(bus.rd_data), 32'hFFFF_FFFF);
            end else begin
                check_eq("rd_data", 32'(bus.rd_data), 32'(rd_q[0].data));
                if (rd_q[0].cyc >= 0) check_eq("rd_cycle", cyc, rd_q[0].cyc);
                void'(rd_q.pop_front());
            end
        end
        if (bus.done) begin
            done_count <= done_count + 1;
            done_cyc   <= cyc;
        end
        if (mem_we != '0) wr_log.push_back('{addr: mem_addr, we: mem_we, data: mem_wdata});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic exp_rd(input logic [DATA_W-1:0] d, input int c);
        rd_q.push_back('{data: d, cyc: c});
    endtask

    task automatic issue_cmd(input logic [1:0] op, input logic [ADDR_W-1:0] addr, input logic [ADDR_W-1:0] len,
                             input logic [LANES-1:0] mask, input logic [DATA_W-1:0] seed,
                             output int acc, output int start);
        int guard = 0;
        while (!bus.cmd_ready && guard < 100) begin
            step();
            guard++;
        end
        check_eq("cmd_ready_idle", 32'(bus.cmd_ready), 1);
        bus.cmd_op    = op;
        bus.cmd_addr  = addr;
        bus.cmd_len   = len;
        bus.cmd_mask  = mask;
        bus.cmd_seed  = seed;
        bus.cmd_valid = 1'b1;
        acc   = cyc;
        start = done_count;
        step();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int start, input int exp_cyc);
        int guard = 0;
        while (done_count == start && guard < 200) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (done_count == start) check_eq({tag, "_done_timeout"}, 0, 1);
        else check_eq({tag, "_done_cycle"}, done_cyc, exp_cyc);
        step();
        check_eq({tag, "_done_one_cycle"}, 32'(bus.done), 0);
    endtask

    logic [DATA_W-1:0] wdat [0:7];

    task automatic do_write(input string tag, input logic [ADDR_W-1:0] addr, input logic [ADDR_W-1:0] len,
                            input logic [LANES-1:0] mask, input logic [15:0] pat, input int npat,
                            input int exp_done_ofs);
        int acc, start, idx;
        idx = 0;
        issue_cmd(OP_WRITE, addr, len, mask, '0, acc, start);
        for (int i = 0; i < npat; i++) begin
            check_eq({tag, "_wr_ready"}, 32'(bus.wr_ready), 1);
            check_eq({tag, "_cmd_ready_busy"}, 32'(bus.cmd_ready), 0);
            bus.wr_valid = pat[i];
            bus.wr_data  = pat[i] ? wdat[idx] : 16'hDEAD;
            if (pat[i]) idx++;
            step();
        end
        bus.wr_valid = 1'b0;
        wait_done(tag, start, acc + exp_done_ofs);
        check_eq({tag, "_wr_ready_idle"}, 32'(bus.wr_ready), 0);
    endtask

    task automatic check_strobe(input string tag, input int i, input logic [ADDR_W-1:0] a,
                                input logic [LANES-1:0] we, input logic [DATA_W-1:0] d);
        if (i >= wr_log.size()) begin
            check_eq({tag, "_strobe_missing"}, wr_log.size(), i + 1);
        end else begin
            check_eq({tag, "_strobe_addr"}, 32'(wr_log[i].addr), 32'(a));
            check_eq({tag, "_strobe_we"}, 32'(wr_log[i].we), 32'(we));
            check_eq({tag, "_strobe_data"}, 32'(wr_log[i].data), 32'(d));
        end
    endtask

    task automatic read_burst(input string tag, input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                              input int n, input logic [DATA_W-1:0] seed);
        int acc, start;
        issue_cmd(op, addr, ADDR_W'(n - 1), '0, seed, acc, start);
        for (int i = 0; i < n; i++) exp_rd(ram[ADDR_W'(addr + ADDR_W'(i))], acc + 2 + i);
        wait_done(tag, start, acc + n + 2);
    endtask

    int acc, start;

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = '0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.cmd_mask  = '0;
        bus.cmd_seed  = '0;
        bus.wr_data   = '0;
        bus.wr_valid  = 1'b0;
        repeat (3) step();

        check_eq("rst_cmd_ready", 32'(bus.cmd_ready), 1);
        check_eq("rst_done", 32'(bus.done), 0);
        check_eq("rst_rd_valid", 32'(bus.rd_valid), 0);
        check_eq("rst_err", 32'(bus.err), 0);
        check_eq("rst_err_addr", 32'(bus.err_addr), 0);
        check_eq("rst_wr_ready", 32'(bus.wr_ready), 0);
        check_eq("rst_mem_we", 32'(mem_we), 0);
        reset = 1'b1;
        step();

        // single write then single read with exact latency
        wdat[0] = 16'hBEEF;
        wr_log.delete();
        do_write("wr1", 14'h0005, 14'h0, 4'hF, 16'h1, 1, 2);
        check_eq("wr1_strobes", wr_log.size(), 1);
        check_strobe("wr1", 0, 14'h0005, 4'hF, 16'hBEEF);
        issue_cmd(OP_READ, 14'h0005, 14'h0, '0, '0, acc, start);
        exp_rd(16'hBEEF, acc + 2);
        wait_done("rd1", start, acc + 3);

        // partial lane write
        wdat[0] = 16'h1234;
        do_write("wr_mask", 14'h0005, 14'h0, 4'b0011, 16'h1, 1, 2);
        issue_cmd(OP_READ, 14'h0005, 14'h0, '0, '0, acc, start);
        exp_rd(16'hBE34, acc + 2);
        wait_done("rd_mask", start, acc + 3);

        // fill across the address wrap
        wr_log.delete();
        issue_cmd(OP_FILL, 14'h3FFE, 14'd3, '0, 16'h00F0, acc, start);
        wait_done("fill", start, acc + 5);
        check_eq("fill_strobes", wr_log.size(), 4);
        check_strobe("fill0", 0, 14'h3FFE, 4'hF, 16'h00F0);
        check_strobe("fill1", 1, 14'h3FFF, 4'hF, 16'h00F1);
        check_strobe("fill2", 2, 14'h0000, 4'hF, 16'h00F2);
        check_strobe("fill3", 3, 14'h0001, 4'hF, 16'h00F3);
        issue_cmd(OP_READ, 14'h3FFE, 14'd3, '0, '0, acc, start);
        for (int i = 0; i < 4; i++) exp_rd(16'h00F0 + 16'(i), acc + 2 + i);
        wait_done("rd_fill", start, acc + 6);

        read_burst("verify_ok", OP_VERIFY, 14'h3FFE, 4, 16'h00F0);
        check_eq("verify_ok_err", 32'(bus.err), 0);

        // every word mismatches: only the first address is kept
        read_burst("verify_all_bad", OP_VERIFY, 14'h3FFE, 4, 16'h00F1);
        check_eq("verify_all_bad_err", 32'(bus.err), 1);
        check_eq("verify_all_bad_err_addr", 32'(bus.err_addr), 32'h3FFE);

        // single corrupted word
        wdat[0] = 16'hAAAA;
        do_write("corrupt", 14'h0000, 14'h0, 4'hF, 16'h1, 1, 2);
        read_burst("verify_bad", OP_VERIFY, 14'h3FFE, 4, 16'h00F0);
        check_eq("verify_bad_err", 32'(bus.err), 1);
        check_eq("verify_bad_err_addr", 32'(bus.err_addr), 32'h0000);
        repeat (3) step();
        check_eq("err_sticky", 32'(bus.err), 1);
        read_burst("read_keeps_err", OP_READ, 14'h0001, 1, '0);
        check_eq("err_sticky_read", 32'(bus.err), 1);
        issue_cmd(OP_VERIFY, 14'h0001, 14'h0, '0, 16'h00F3, acc, start);
        check_eq("verify_clears_err", 32'(bus.err), 0);
        exp_rd(16'h00F3, acc + 2);
        wait_done("verify_clean", start, acc + 3);
        check_eq("verify_clean_err", 32'(bus.err), 0);

        // stalled write burst: valid pattern 1,0,0,1,1,0,1
        wdat[0] = 16'h1111; wdat[1] = 16'h2222; wdat[2] = 16'h3333; wdat[3] = 16'h4444;
        wr_log.delete();
        do_write("wr_stall", 14'h0100, 14'd3, 4'hF, 16'h0059, 7, 8);
        check_eq("wr_stall_strobes", wr_log.size(), 4);
        for (int i = 0; i < 4; i++)
            check_strobe("wr_stall", i, 14'h0100 + 14'(i), 4'hF, wdat[i]);
        read_burst("rd_stall", OP_READ, 14'h0100, 4, '0);

        // reset asserted on fill beat 2
        wr_log.delete();
        issue_cmd(OP_FILL, 14'h0200, 14'd7, '0, 16'h0050, acc, start);
        step();
        step();
        reset = 1'b0;
        #1;
        check_eq("rst_mid_mem_we", 32'(mem_we), 0);
        step();
        reset = 1'b1;
        check_eq("rst_mid_cmd_ready", 32'(bus.cmd_ready), 1);
        check_eq("rst_mid_wr_ready", 32'(bus.wr_ready), 0);
        repeat (10) step();
        check_eq("rst_mid_no_done", done_count, start);
        check_eq("rst_mid_strobes", wr_log.size(), 2);
        check_strobe("rst_mid0", 0, 14'h0200, 4'hF, 16'h0050);
        check_strobe("rst_mid1", 1, 14'h0201, 4'hF, 16'h0051);
        issue_cmd(OP_READ, 14'h0200, 14'd2, '0, '0, acc, start);
        exp_rd(16'h0050, acc + 2);
        exp_rd(16'h0051, acc + 3);
        exp_rd(16'h0000, acc + 4);
        wait_done("rd_after_rst", start, acc + 5);

        check_eq("scoreboard_empty", rd_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
